// File: rtl/bus_source_arbiter.sv
// Round-robin owner select for the shared 32-bit datapath bus.
// One-hot grant plus code, a dead cycle between owners and bounded hold.
module bus_source_arbiter #(
  parameter int N_SRC    = 24,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [N_SRC-1:0] req,
  output logic [31:0]      grant,
  output logic [4:0]       code,
  output logic             busy,
  output logic             timeout
);

  localparam int HW =
    (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    GAP
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     grant_q, grant_d;
  logic [4:0]      code_q, code_d;
  logic [4:0]      rr_q, rr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            timeout_q, timeout_d;

  logic [4:0]      win;
  logic            found;
  logic            own_req;
  logic            at_max;
  logic [4:0]      rr_next;

  // First requester at or after rr_q, wrapping at N_SRC-1.
  always_comb begin
    int idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_SRC; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!found && req[idx[4:0]]) begin
        found = 1'b1;
        win   = idx[4:0];
      end
    end
  end

  assign own_req = req[code_q];
  assign at_max  = (MAX_HOLD != 0) &&
                   (hold_q == HW'(MAX_HOLD));
  assign rr_next = (code_q == 5'(N_SRC - 1)) ?
                   5'd0 : code_q + 5'd1;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    code_d    = code_q;
    rr_d      = rr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        if (found) begin
          state_d = OWN;
          grant_d = 32'd1 << win;
          code_d  = win;
          hold_d  = HW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        if (!own_req || at_max) begin
          state_d   = GAP;
          grant_d   = '0;
          code_d    = 5'd31;
          rr_d      = rr_next;
          timeout_d = own_req;
        end else if (hold_q != '1) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      code_q    <= 5'd31;
      rr_q      <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      code_q    <= code_d;
      rr_q      <= rr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign code    = code_q;
  assign busy    = (state_q == OWN);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Directed bench for bus_source_arbiter.
// Three instances cover MAX_HOLD of 8, 2 and 0.
module tb_bus_source_arbiter;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic [23:0] req = '0;

  logic [31:0] g8, g2, g0;
  logic [4:0]  c8, c2, c0;
  logic        b8, b2, b0;
  logic        t8, t2, t0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bus_source_arbiter #(.N_SRC(24), .MAX_HOLD(8)) dut (
    .clk(clk), .clear(clear), .req(req),
    .grant(g8), .code(c8), .busy(b8), .timeout(t8)
  );

  bus_source_arbiter #(.N_SRC(24), .MAX_HOLD(2)) dut2 (
    .clk(clk), .clear(clear), .req(req),
    .grant(g2), .code(c2), .busy(b2), .timeout(t2)
  );

  bus_source_arbiter #(.N_SRC(24), .MAX_HOLD(0)) dut0 (
    .clk(clk), .clear(clear), .req(req),
    .grant(g0), .code(c0), .busy(b0), .timeout(t0)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_all;
    clear = 1'b0;
    #2;
    clear = 1'b1;
  endtask

  int own3[4] = '{3, 7, 20, 3};

  initial begin
    // reset holds everything off despite requests
    req = 24'hFFFFFF;
    tick;
    tick;
    check("rst_grant", g8, 32'h0);
    check("rst_code", 32'(c8), 31);
    check("rst_busy", 32'(b8), 0);
    check("rst_tmo", 32'(t8), 0);
    #2;
    clear = 1'b1;
    tick;
    check("rst_first_grant", g8, 32'h1);
    check("rst_first_code", 32'(c8), 0);
    check("rst_first_busy", 32'(b8), 1);
    req = '0;
    tick;
    tick;

    // single requester, dropped after 3 cycles
    rst_all;
    req = 24'h000020;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("single_grant", g8, 32'h20);
      check("single_code", 32'(c8), 5);
      check("single_tmo", 32'(t8), 0);
    end
    req = '0;
    tick;
    check("single_gap", g8, 32'h0);
    check("single_gap_code", 32'(c8), 31);
    check("single_gap_busy", 32'(b8), 0);
    check("single_gap_tmo", 32'(t8), 0);
    tick;
    check("single_idle", g8, 32'h0);
    check("single_idle_tmo", 32'(t8), 0);

    // round robin with MAX_HOLD=2
    rst_all;
    req = 24'h100088;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("rr_own_a", 32'(c2), own3[k]);
      check("rr_grant_a", g2, 32'h1 << own3[k]);
      tick;
      check("rr_own_b", 32'(c2), own3[k]);
      check("rr_tmo_b", 32'(t2), 0);
      tick;
      check("rr_gap", g2, 32'h0);
      check("rr_gap_tmo", 32'(t2), 1);
    end
    req = '0;
    tick;
    check("rr_idle", g2, 32'h0);

    // wrap: pointer parked at 23
    rst_all;
    req = 24'h400000;
    tick;
    check("wrap_own22", 32'(c8), 22);
    req = 24'h800002;
    tick;
    check("wrap_gap", g8, 32'h0);
    tick;
    check("wrap_23", 32'(c8), 23);
    check("wrap_23g", g8, 32'h800000);
    req = 24'h000002;
    tick;
    check("wrap_gap2", g8, 32'h0);
    tick;
    check("wrap_1", 32'(c8), 1);
    req = 24'h400000;
    tick;
    tick;
    check("wrap_own22b", 32'(c8), 22);
    req = '0;
    tick;
    tick;
    req = 24'h000001;
    tick;
    check("wrap_0", 32'(c8), 0);
    req = '0;
    tick;
    tick;

    // sole requester stuck: timeout vs unlimited hold
    rst_all;
    req = 24'h010000;
    for (int i = 0; i < 8; i++) begin
      tick;
      check("hold8_grant", g8, 32'h10000);
      check("hold0_grant", g0, 32'h10000);
    end
    tick;
    check("hold8_gap", g8, 32'h0);
    check("hold8_tmo", 32'(t8), 1);
    check("hold0_keep", g0, 32'h10000);
    check("hold0_tmo", 32'(t0), 0);
    tick;
    check("hold8_regrant", g8, 32'h10000);
    check("hold8_tmo_clr", 32'(t8), 0);
    for (int i = 0; i < 10; i++) tick;
    check("hold0_long", g0, 32'h10000);
    check("hold0_busy", 32'(b0), 1);
    req = '0;
    tick;
    tick;

    // async reset mid-ownership
    rst_all;
    req = 24'h000200;
    tick;
    check("ar_own9", 32'(c8), 9);
    req = '0;
    tick;
    req = 24'h000200;
    tick;
    check("ar_own9b", 32'(c8), 9);
    #2;
    clear = 1'b0;
    #1;
    check("ar_grant", g8, 32'h0);
    check("ar_code", 32'(c8), 31);
    check("ar_busy", 32'(b8), 0);
    clear = 1'b1;
    req = 24'h001200;
    tick;
    check("ar_restart", 32'(c8), 9);
    check("ar_restart_g", g8, 32'h200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
